cmu: RTL

Cache management unit that drives the 2-way set-associative cache storage array. It accepts CPU load/store requests, runs lookups and stalls the CPU on a miss. It writes back a dirty victim line to memory, refills the line from memory, then replays the access as a hit. It sits between the CPU data port, the cache array and the memory port (write-back, write-allocate).

---
 rtl/cmu_pkg.sv | 33 +++
 rtl/cmu_if.sv | 23 ++
 rtl/cmu.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cmu_pkg.sv
// rtl/cmu_pkg.sv - cmu address-field layout, FSM state encodings and line address helper
// Shared by the cache management unit and its memory interface. The address
// splits as tag [31:9], set index [8:4], word-in-line [3:2], byte [1:0].
package cmu_pkg;

    localparam int ADDR_BITS           = 32;
    localparam int TAG_BITS            = 23;
    localparam int SET_INDEX_WIDTH     = 5;
    localparam int ELEMENT_WORDS_WIDTH = 2;

    localparam int WORD_LSB  = 2;
    localparam int INDEX_LSB = WORD_LSB + ELEMENT_WORDS_WIDTH;
    localparam int TAG_LSB   = INDEX_LSB + SET_INDEX_WIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_BACK  = 3'd2;
    localparam logic [2:0] S_FILL  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    // Full-word access code used for line refill writes into the array.
    localparam logic [2:0] UBHW_WORD = 3'b010;

    // Word-aligned address of one word of a cache line.
    function automatic logic [ADDR_BITS-1:0] line_word_addr(
        input logic [TAG_BITS-1:0]            tag,
        input logic [SET_INDEX_WIDTH-1:0]     index,
        input logic [ELEMENT_WORDS_WIDTH-1:0] word
    );
        return {tag, index, word, 2'b00};
    endfunction

endpackage

// File: rtl/cmu_if.sv
// rtl/cmu_if.sv - word-wide memory port between the cache management unit and memory
// master: cmu side (drives mem_cs_o, mem_we_o, mem_addr_o, mem_data_o)
// slave : memory side (drives mem_data_i and the one-cycle mem_ack_i pulse)
interface cmu_if;
    import cmu_pkg::*;

    logic                 mem_cs_o;
    logic                 mem_we_o;
    logic [ADDR_BITS-1:0] mem_addr_o;
    logic [31:0]          mem_data_o;
    logic [31:0]          mem_data_i;
    logic                 mem_ack_i;

    modport master (
        output mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );

    modport slave (
        input  mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );
endinterface

// File: rtl/cmu.sv
// rtl/cmu.sv - write-back, write-allocate controller for a 2-way set-associative cache
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   addr_rw/en_r/en_w/...    CPU request; data_r/stall back to the CPU
//   cache_*  (out)           lookup/edit/refill commands to the cache array
//   cache_hit/valid/dirty/tag/dout (in)  registered array status (one cycle after lookup)
//   mem      (cmu_if.master) word-at-a-time memory port for writeback and refill
module cmu
    import cmu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr_rw,
    input  logic                 en_r,
    input  logic                 en_w,
    input  logic [2:0]           u_b_h_w,
    input  logic [31:0]          data_w,
    output logic [31:0]          data_r,
    output logic                 stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_edit,
    output logic                 cache_store,
    output logic                 cache_invalid,
    output logic [2:0]           cache_u_b_h_w,
    output logic [31:0]          cache_din,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    input  logic [31:0]          cache_dout,
    cmu_if.master                mem
);

    logic [2:0]                     state;
    logic [ADDR_BITS-1:0]           req_addr;
    logic                           req_wr;
    logic [2:0]                     req_ubhw;
    logic [31:0]                    req_data;
    logic [TAG_BITS-1:0]            victim_tag;
    logic [ELEMENT_WORDS_WIDTH-1:0] cnt;
    logic                           primed;

    logic                           req;
    logic [SET_INDEX_WIDTH-1:0]     req_index;
    logic [TAG_BITS-1:0]            req_tag;
    logic [ADDR_BITS-1:0]           back_addr;
    logic [ADDR_BITS-1:0]           fill_addr;

    assign req       = en_r | en_w;
    assign req_index = req_addr[INDEX_LSB +: SET_INDEX_WIDTH];
    assign req_tag   = req_addr[TAG_LSB +: TAG_BITS];
    assign back_addr = line_word_addr(victim_tag, req_index, cnt);
    assign fill_addr = line_word_addr(req_tag, req_index, cnt);

    // Stall tracks the live request: a request dropped mid-miss still runs to
    // completion internally, but the CPU is no longer held.
    assign stall  = req & ~((state == S_CHECK) & cache_hit);
    assign data_r = cache_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            req_addr   <= '0;
            req_wr     <= 1'b0;
            req_ubhw   <= '0;
            req_data   <= '0;
            victim_tag <= '0;
            cnt        <= '0;
            primed     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        req_addr <= addr_rw;
                        req_wr   <= en_w;
                        req_ubhw <= u_b_h_w;
                        req_data <= data_w;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cache_hit) begin
                        state <= S_IDLE;
                    end else if (cache_valid && cache_dirty) begin
                        victim_tag <= cache_tag;
                        cnt        <= '0;
                        primed     <= 1'b0;
                        state      <= S_BACK;
                    end else begin
                        cnt   <= '0;
                        state <= S_FILL;
                    end
                end
                S_BACK: begin
                    // The array needs one cycle to present the victim word
                    // before it can be handed to memory.
                    if (!primed) begin
                        primed <= 1'b1;
                    end else if (mem.mem_ack_i) begin
                        primed <= 1'b0;
                        cnt    <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (mem.mem_ack_i) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    state <= S_CHECK;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cache_addr     = '0;
        cache_load     = 1'b0;
        cache_edit     = 1'b0;
        cache_store    = 1'b0;
        cache_invalid  = 1'b0;
        cache_u_b_h_w  = '0;
        cache_din      = '0;
        mem.mem_cs_o   = 1'b0;
        mem.mem_we_o   = 1'b0;
        mem.mem_addr_o = '0;
        mem.mem_data_o = '0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    cache_addr    = addr_rw;
                    cache_load    = en_r & ~en_w;
                    cache_edit    = en_w;
                    cache_din     = data_w;
                    cache_u_b_h_w = u_b_h_w;
                end
            end
            S_CHECK: begin
                cache_addr = req_addr;
            end
            S_BACK: begin
                // Address is held constant for the whole word, so the
                // registered dout stays stable while mem_cs_o is high.
                cache_addr = back_addr;
                if (primed) begin
                    mem.mem_cs_o   = 1'b1;
                    mem.mem_we_o   = 1'b1;
                    mem.mem_addr_o = back_addr;
                    mem.mem_data_o = cache_dout;
                end
            end
            S_FILL: begin
                cache_addr     = fill_addr;
                mem.mem_cs_o   = 1'b1;
                mem.mem_addr_o = fill_addr;
                if (mem.mem_ack_i) begin
                    cache_store   = 1'b1;
                    cache_din     = mem.mem_data_i;
                    cache_u_b_h_w = UBHW_WORD;
                end
            end
            S_WAIT: begin
                cache_addr    = req_addr;
                cache_load    = ~req_wr;
                cache_edit    = req_wr;
                cache_din     = req_data;
                cache_u_b_h_w = req_ubhw;
            end
            default: begin
            end
        endcase
    end

endmodule
